// File: rtl/ureg_shift_if.sv
// Bundled control, data and status signals of the universal shift register.
interface ureg_shift_if #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
);
  logic             preset_n;
  logic             clear_n;
  logic [2:0]       mode;
  logic [WIDTH-1:0] d;
  logic             sin_l;
  logic             sin_r;
  logic             start;
  logic             dir;
  logic [AMT_W-1:0] amt;
  logic [WIDTH-1:0] q;
  logic             sout_l;
  logic             sout_r;
  logic             busy;
  logic             done;

  modport master (
    output preset_n, clear_n, mode, d, sin_l, sin_r, start, dir, amt,
    input  q, sout_l, sout_r, busy, done
  );

  modport slave (
    input  preset_n, clear_n, mode, d, sin_l, sin_r, start, dir, amt,
    output q, sout_l, sout_r, busy, done
  );
endinterface

// File: rtl/ureg_shift.sv
// Universal shift register clocked on the falling edge, with a multi-cycle
// rotate burst engine, synchronous preset/clear and asynchronous reset.
module ureg_shift #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
) (
  input logic        clk,
  input logic        rst,
  ureg_shift_if.slave bus
);

  localparam logic [2:0] MODE_HOLD  = 3'b000;
  localparam logic [2:0] MODE_LOAD  = 3'b001;
  localparam logic [2:0] MODE_SHL   = 3'b010;
  localparam logic [2:0] MODE_SHR   = 3'b011;
  localparam logic [2:0] MODE_ROL   = 3'b100;
  localparam logic [2:0] MODE_ROR   = 3'b101;
  localparam logic [2:0] MODE_ASR   = 3'b110;
  localparam logic [2:0] MODE_BURST = 3'b111;

  logic [WIDTH-1:0] q_r,    q_nxt;
  logic             busy_r, busy_nxt;
  logic             done_r, done_nxt;
  logic [AMT_W-1:0] rem_r,  rem_nxt;
  logic             dir_r,  dir_nxt;

  function automatic logic [WIDTH-1:0] rot1(input logic [WIDTH-1:0] v,
                                            input logic right);
    return right ? {v[0], v[WIDTH-1:1]} : {v[WIDTH-2:0], v[WIDTH-1]};
  endfunction

  function automatic logic [WIDTH-1:0] asr1(input logic signed [WIDTH-1:0] v);
    return v >>> 1;
  endfunction

  // The start edge performs the first rotate, so rem holds rotates still owed;
  // busy with rem==0 marks the completion edge, where a new start may be taken.
  always_comb begin
    q_nxt    = q_r;
    busy_nxt = busy_r;
    done_nxt = 1'b0;
    rem_nxt  = rem_r;
    dir_nxt  = dir_r;
    if (!(bus.preset_n && bus.clear_n)) begin
      busy_nxt = 1'b0;
      rem_nxt  = '0;
      case ({bus.preset_n, bus.clear_n})
        2'b01:   q_nxt = '1;
        2'b10:   q_nxt = '0;
        default: q_nxt = 'x;
      endcase
    end else if (busy_r && (rem_r != '0)) begin
      q_nxt   = rot1(q_r, dir_r);
      rem_nxt = rem_r - 1'b1;
    end else begin
      if (busy_r) begin
        busy_nxt = 1'b0;
        done_nxt = 1'b1;
      end
      if (bus.mode == MODE_BURST) begin
        if (bus.start) begin
          dir_nxt = bus.dir;
          if (bus.amt == '0) begin
            done_nxt = 1'b1;
          end else begin
            busy_nxt = 1'b1;
            rem_nxt  = bus.amt - 1'b1;
            q_nxt    = rot1(q_r, bus.dir);
          end
        end
      end else if (!busy_r) begin
        case (bus.mode)
          MODE_HOLD: q_nxt = q_r;
          MODE_LOAD: q_nxt = bus.d;
          MODE_SHL:  q_nxt = {q_r[WIDTH-2:0], bus.sin_l};
          MODE_SHR:  q_nxt = {bus.sin_r, q_r[WIDTH-1:1]};
          MODE_ROL:  q_nxt = rot1(q_r, 1'b0);
          MODE_ROR:  q_nxt = rot1(q_r, 1'b1);
          MODE_ASR:  q_nxt = asr1(q_r);
          default:   q_nxt = q_r;
        endcase
      end
    end
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      q_r    <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      rem_r  <= '0;
      dir_r  <= 1'b0;
    end else begin
      q_r    <= q_nxt;
      busy_r <= busy_nxt;
      done_r <= done_nxt;
      rem_r  <= rem_nxt;
      dir_r  <= dir_nxt;
    end
  end

  assign bus.q      = q_r;
  assign bus.sout_l = q_r[WIDTH-1];
  assign bus.sout_r = q_r[0];
  assign bus.busy   = busy_r;
  assign bus.done   = done_r;

endmodule

// File: tb/tb_ureg_shift.sv
// Directed and randomized bench for ureg_shift against a burst-timeline model.
module tb_ureg_shift;
  localparam int WIDTH = 8;
  localparam int AMT_W = 3;
  localparam int MASK  = (1 << WIDTH) - 1;

  logic clk = 1'b1;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  ureg_shift_if #(.WIDTH(WIDTH), .AMT_W(AMT_W)) bus ();

  ureg_shift #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Model: a burst is described by its start value, length and edges elapsed.
  int mq, mq0, mk, mn;
  bit mbusy, mdone, mdir;

  function automatic int rotn(input int v, input int k, input bit right);
    int kk;
    kk = k % WIDTH;
    if (right) return ((v >> kk) | (v << (WIDTH - kk))) & MASK;
    else       return ((v << kk) | (v >> (WIDTH - kk))) & MASK;
  endfunction

  task automatic model_reset();
    mq = 0; mq0 = 0; mk = 0; mn = 0; mbusy = 0; mdone = 0; mdir = 0;
  endtask

  task automatic model_edge();
    bit fin;
    mdone = 0;
    if (!bus.preset_n || !bus.clear_n) begin
      mq    = !bus.preset_n ? MASK : 0;
      mbusy = 0;
    end else if (mbusy && mk < mn) begin
      mk++;
      mq = rotn(mq0, mk, mdir);
    end else begin
      fin = mbusy;
      if (mbusy) begin mbusy = 0; mdone = 1; end
      if (bus.mode == 3'd7) begin
        if (bus.start) begin
          if (bus.amt == 0) mdone = 1;
          else begin
            mq0 = mq; mn = int'(bus.amt); mk = 1; mdir = bus.dir; mbusy = 1;
            mq  = rotn(mq0, 1, mdir);
          end
        end
      end else if (!fin) begin
        case (bus.mode)
          3'd1: mq = int'(bus.d);
          3'd2: mq = ((mq << 1) | int'(bus.sin_l)) & MASK;
          3'd3: mq = (mq >> 1) | (int'(bus.sin_r) << (WIDTH - 1));
          3'd4: mq = rotn(mq, 1, 1'b0);
          3'd5: mq = rotn(mq, 1, 1'b1);
          3'd6: mq = (mq >> 1) | (mq & (1 << (WIDTH - 1)));
          default: ;
        endcase
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    check("q",      32'(bus.q),  32'(mq));
    check("busy",   32'(bus.busy), 32'(mbusy));
    check("done",   32'(bus.done), 32'(mdone));
    check("sout_l", 32'(bus.sout_l), 32'((mq >> (WIDTH - 1)) & 1));
    check("sout_r", 32'(bus.sout_r), 32'(mq & 1));
  endtask

  task automatic step();
    @(negedge clk);
    model_edge();
    @(posedge clk);
    check_model();
  endtask

  task automatic idle_inputs();
    bus.preset_n = 1; bus.clear_n = 1; bus.mode = 3'd0; bus.d = '0;
    bus.sin_l = 0; bus.sin_r = 0; bus.start = 0; bus.dir = 0; bus.amt = '0;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    check("rst_q", 32'(bus.q), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_done", 32'(bus.done), 32'h0);
    rst = 1'b0;

    bus.mode = 3'd1; bus.d = 8'hA5; step();
    check("load_a5", 32'(bus.q), 32'hA5);
    bus.mode = 3'd2; bus.sin_l = 1; step();
    check("shl_4b", 32'(bus.q), 32'h4B);

    bus.mode = 3'd1; bus.d = 8'h81; step();
    bus.mode = 3'd6; step();
    check("asr_c0", 32'(bus.q), 32'hC0);
    bus.mode = 3'd3; bus.sin_r = 0; step();
    check("shr_60", 32'(bus.q), 32'h60);

    bus.mode = 3'd1; bus.d = 8'h01; step();
    bus.mode = 3'd7; bus.start = 1; bus.dir = 0; bus.amt = 3; step();
    check("b1_q", 32'(bus.q), 32'h02);
    check("b1_busy", 32'(bus.busy), 32'h1);
    bus.mode = 3'd1; bus.start = 0; bus.d = 8'hFF; step();
    check("b2_busy", 32'(bus.busy), 32'h1);
    step();
    check("b3_q", 32'(bus.q), 32'h08);
    check("b3_busy", 32'(bus.busy), 32'h1);
    bus.mode = 3'd0; step();
    check("b4_busy", 32'(bus.busy), 32'h0);
    check("b4_done", 32'(bus.done), 32'h1);
    check("b4_q", 32'(bus.q), 32'h08);
    step();
    check("b5_done", 32'(bus.done), 32'h0);

    bus.mode = 3'd7; bus.start = 1; bus.amt = 5; step();
    bus.start = 0; step();
    bus.clear_n = 0; step();
    check("clr_q", 32'(bus.q), 32'h00);
    check("clr_busy", 32'(bus.busy), 32'h0);
    bus.clear_n = 1; bus.mode = 3'd0; step();
    check("clr_nodone", 32'(bus.done), 32'h0);
    step();

    bus.mode = 3'd1; bus.d = 8'h3C; step();
    bus.mode = 3'd7; bus.start = 1; bus.amt = 0; step();
    check("z_q", 32'(bus.q), 32'h3C);
    check("z_busy", 32'(bus.busy), 32'h0);
    check("z_done", 32'(bus.done), 32'h1);
    bus.start = 0; step();
    check("z_done_off", 32'(bus.done), 32'h0);
    bus.start = 1; bus.dir = 1; bus.amt = 2; step();
    check("bb1_q", 32'(bus.q), 32'h1E);
    bus.dir = 0; bus.amt = 1; step();
    check("bb2_q", 32'(bus.q), 32'h0F);
    step();
    check("bb3_done", 32'(bus.done), 32'h1);
    check("bb3_busy", 32'(bus.busy), 32'h1);
    check("bb3_q", 32'(bus.q), 32'h1E);
    bus.mode = 3'd0; bus.start = 0; step();
    check("bb4_done", 32'(bus.done), 32'h1);
    check("bb4_busy", 32'(bus.busy), 32'h0);
    step();

    bus.mode = 3'd1; bus.d = 8'h5A; step();
    bus.mode = 3'd7; bus.start = 1; bus.amt = 7; step();
    bus.start = 0; step();
    rst = 1'b1;
    #1;
    check("arst_q", 32'(bus.q), 32'h0);
    check("arst_busy", 32'(bus.busy), 32'h0);
    check("arst_done", 32'(bus.done), 32'h0);
    model_reset();
    @(posedge clk);
    rst = 1'b0;
    bus.mode = 3'd0; step();
    step();

    for (int i = 0; i < 400; i++) begin
      bus.preset_n = ($urandom_range(0, 24) != 0);
      bus.clear_n  = ($urandom_range(0, 24) != 0);
      if (!bus.preset_n && !bus.clear_n) bus.clear_n = 1;
      bus.mode  = 3'($urandom_range(0, 7));
      bus.d     = 8'($urandom);
      bus.sin_l = 1'($urandom);
      bus.sin_r = 1'($urandom);
      bus.start = ($urandom_range(0, 2) != 0);
      bus.dir   = 1'($urandom);
      bus.amt   = 3'($urandom_range(0, 7));
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ureg_shift.md
UREG_SHIFT -- requirements
Module: ureg_shift

Interface
REQ-001 Parameter WIDTH, default 8: register width in bits; legal range 2..32.
REQ-002 Parameter AMT_W, default 3: width of the burst-shift amount; 2^AMT_W-1 < WIDTH.
REQ-003 clk  input  1  clock; all state changes on the falling edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 preset_n  input  1  synchronous preset, active-low; sets all bits to 1.
REQ-006 clear_n  input  1  synchronous clear, active-low; sets all bits to 0.
REQ-007 mode  input  3  operation select (see Function).
REQ-008 d  input  WIDTH  parallel load data.
REQ-009 sin_l  input  1  serial input, shifted in at bit 0 on shift-left.
REQ-010 sin_r  input  1  serial input, shifted in at bit WIDTH-1 on shift-right.
REQ-011 start  input  1  begin a burst shift; sampled only when mode=3'b111.
REQ-012 dir  input  1  burst direction: 0 = rotate left, 1 = rotate right.
REQ-013 amt  input  AMT_W  number of single-bit rotates in the burst.
REQ-014 q  output  WIDTH  register contents.
REQ-015 sout_l  output  1  equals q[WIDTH-1], combinational.
REQ-016 sout_r  output  1  equals q[0], combinational.
REQ-017 busy  output  1  high while a burst is in progress.
REQ-018 done  output  1  one-cycle pulse on burst completion.

Function
REQ-019 Priority per falling edge: rst > synchronous preset/clear > active burst > mode.
REQ-020 {preset_n,clear_n}=2'b01: q <= all ones; 2'b10: q <= all zeros; 2'b00: q <= all X (illegal, simulation only); 2'b11: normal operation.
REQ-021 A synchronous preset or clear during a burst aborts it: busy <= 0; done stays 0.
REQ-022 mode 000 hold; 001 q <= d; 010 q <= {q[WIDTH-2:0], sin_l}; 011 q <= {sin_r, q[WIDTH-1:1]}.
REQ-023 mode 100 rotate left by 1; 101 rotate right by 1; 110 arithmetic shift right by 1, keeping q[WIDTH-1].
REQ-024 mode 111 with start=1 and busy=0: latch dir and amt; if amt=0, no rotate occurs and done pulses on the next edge with busy staying 0.
REQ-025 mode 111 with start=1, busy=0 and amt=N>0: busy rises on that edge; q rotates one position per edge for N edges; busy falls on the edge after the last rotate; done is high for exactly that cycle.
REQ-026 While busy=1: mode, d, start, dir and amt are ignored; the latched dir and amt govern the burst.
REQ-027 done is high for exactly one cycle per completed burst and is otherwise 0.
REQ-028 A new start is accepted on the same edge at which done is asserted (back-to-back bursts).
REQ-029 mode 111 with start=0: hold.
REQ-030 Internal remaining-count counter is AMT_W bits wide and never wraps below zero.

Reset
REQ-031 rst=1 forces, asynchronously: q=0, busy=0, done=0, remaining count=0, latched dir=0.
REQ-032 rst overrides all other inputs; on release the block is idle, and the first falling edge with rst=0 obeys REQ-019.
REQ-033 rst asserted mid-burst abandons the burst; no done pulse follows.

Verification
REQ-034 WIDTH=8: rst pulse, then mode=001 with d=8'hA5 -> q=8'hA5; mode=010 with sin_l=1 -> q=8'h4B.
REQ-035 q=8'h81, mode=110 -> q=8'hC0; mode=011 with sin_r=0 -> q=8'h60.
REQ-036 q=8'h01, mode=111, start=1, dir=0, amt=3 -> busy high for 3 edges, q=8'h08, then a single done pulse.
REQ-037 Burst in progress, clear_n=0 for 1 edge -> q=8'h00, busy=0, no done pulse.
REQ-038 amt=0 burst -> q unchanged, busy never high, done pulses once; back-to-back start at the done edge -> second burst runs.
REQ-039 rst asserted between clock edges during a burst -> q, busy and done go to 0 immediately, without waiting for a clock edge.
